// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache in front of the instruction buffer.
// Returns up to N_WAY consecutive hit instructions combinationally, and
// refills missing 8-byte lines through a tagged memory port using a miss FSM.
// Optional next-line prefetch is built when ICACHE_PREFETCH_EN is defined.
`ifndef N_WAY
`define N_WAY 3
`endif

module icache_fetch #(
  parameter int unsigned N_WAY       = `N_WAY,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CACHE_LINES = 32,
  parameter int unsigned MEM_TAG_W   = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [XLEN-1:0]                buff2Icache_addr,
  input  logic [$clog2(N_WAY):0]         buff2Icache_count,
  output logic [N_WAY-1:0][XLEN-1:0]     Icache2buff_addr,
  output logic [N_WAY-1:0][XLEN-1:0]     Icache2buff_data,
  output logic [N_WAY-1:0]               Icache2buff_valid,
  output logic [$clog2(N_WAY):0]         Icache2buff_hit_count,
  output logic [1:0]                     proc2Imem_command,
  output logic [XLEN-1:0]                proc2Imem_addr,
  input  logic [MEM_TAG_W-1:0]           Imem2proc_response,
  input  logic [63:0]                    Imem2proc_data,
  input  logic [MEM_TAG_W-1:0]           Imem2proc_tag
);

  localparam int unsigned IDX_W = $clog2(CACHE_LINES);
  localparam int unsigned TAG_W = XLEN - 3 - IDX_W;
  localparam int unsigned CNT_W = $clog2(N_WAY) + 1;
  localparam logic [1:0]  CMD_NONE = 2'd0;
  localparam logic [1:0]  CMD_LOAD = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
`ifdef ICACHE_PREFETCH_EN
    S_WAIT   = 2'd2,
    S_PF_REQ = 2'd3
`else
    S_WAIT   = 2'd2
`endif
  } state_e;

  logic [CACHE_LINES-1:0] line_valid_q;
  logic [TAG_W-1:0]       line_tag_q  [CACHE_LINES];
  logic [63:0]            line_data_q [CACHE_LINES];

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        req_addr_q, req_addr_d;
  logic [MEM_TAG_W-1:0]   pend_tag_q, pend_tag_d;
  logic [1:0]             cmd_q, cmd_d;
  logic [XLEN-1:0]        mem_addr_q, mem_addr_d;
  logic                   fill_en;
  logic [IDX_W-1:0]       fill_idx;

  logic [CNT_W-1:0]       eff_cnt;
  logic                   chain;
  logic                   miss_found;
  logic [XLEN-1:0]        miss_line;
  logic [XLEN-1:0]        slot_addr;
  logic [IDX_W-1:0]       slot_idx;
  logic                   slot_hit;

`ifdef ICACHE_PREFETCH_EN
  logic                   pf_q, pf_d;
  logic [XLEN-1:0]        pf_addr;
  logic [IDX_W-1:0]       pf_idx;
  logic                   pf_present;
`endif

  assign fill_idx = req_addr_q[3 +: IDX_W];

  // Hit lookup: contiguous valid slots from slot 0, and the first missing line
  always_comb begin
    eff_cnt               = (buff2Icache_count > CNT_W'(N_WAY)) ? CNT_W'(N_WAY) : buff2Icache_count;
    chain                 = 1'b1;
    miss_found            = 1'b0;
    miss_line             = '0;
    slot_addr             = '0;
    slot_idx              = '0;
    slot_hit              = 1'b0;
    Icache2buff_addr      = '0;
    Icache2buff_data      = '0;
    Icache2buff_valid     = '0;
    Icache2buff_hit_count = '0;
    for (int unsigned i = 0; i < N_WAY; i++) begin
      slot_addr = buff2Icache_addr + XLEN'(4 * i);
      slot_idx  = slot_addr[3 +: IDX_W];
      slot_hit  = line_valid_q[slot_idx] && (line_tag_q[slot_idx] == slot_addr[XLEN-1 -: TAG_W]);
      if (CNT_W'(i) < eff_cnt) begin
        if (chain && slot_hit) begin
          Icache2buff_valid[i]  = 1'b1;
          Icache2buff_addr[i]   = slot_addr;
          Icache2buff_data[i]   = slot_addr[2] ? XLEN'(line_data_q[slot_idx][63:32])
                                                : XLEN'(line_data_q[slot_idx][31:0]);
          Icache2buff_hit_count = Icache2buff_hit_count + CNT_W'(1);
        end else begin
          if (chain) begin
            miss_found = 1'b1;
            miss_line  = {slot_addr[XLEN-1:3], 3'b000};
          end
          chain = 1'b0;
        end
      end
    end
  end

`ifdef ICACHE_PREFETCH_EN
  // Next sequential line after the line being filled
  always_comb begin
    pf_addr    = req_addr_q + XLEN'(8);
    pf_idx     = pf_addr[3 +: IDX_W];
    pf_present = line_valid_q[pf_idx] && (line_tag_q[pf_idx] == pf_addr[XLEN-1 -: TAG_W]);
  end
`endif

  // Miss FSM next state and registered memory command
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    pend_tag_d = pend_tag_q;
    fill_en    = 1'b0;
`ifdef ICACHE_PREFETCH_EN
    pf_d       = pf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (miss_found) begin
          req_addr_d = miss_line;
          state_d    = S_REQ;
`ifdef ICACHE_PREFETCH_EN
          pf_d       = 1'b0;
`endif
        end
      end
`ifdef ICACHE_PREFETCH_EN
      S_REQ, S_PF_REQ: begin
`else
      S_REQ: begin
`endif
        if (Imem2proc_response != '0) begin
          pend_tag_d = Imem2proc_response;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if ((Imem2proc_tag != '0) && (Imem2proc_tag == pend_tag_q)) begin
          fill_en = 1'b1;
          state_d = S_IDLE;
`ifdef ICACHE_PREFETCH_EN
          if (!pf_q && !pf_present) begin
            req_addr_d = pf_addr;
            pf_d       = 1'b1;
            state_d    = S_PF_REQ;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef ICACHE_PREFETCH_EN
    cmd_d      = ((state_d == S_REQ) || (state_d == S_PF_REQ)) ? CMD_LOAD : CMD_NONE;
`else
    cmd_d      = (state_d == S_REQ) ? CMD_LOAD : CMD_NONE;
`endif
    mem_addr_d = (cmd_d == CMD_LOAD) ? req_addr_d : '0;
  end

  // FSM and request registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      pend_tag_q <= '0;
      cmd_q      <= CMD_NONE;
      mem_addr_q <= '0;
`ifdef ICACHE_PREFETCH_EN
      pf_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      pend_tag_q <= pend_tag_d;
      cmd_q      <= cmd_d;
      mem_addr_q <= mem_addr_d;
`ifdef ICACHE_PREFETCH_EN
      pf_q       <= pf_d;
`endif
    end
  end

  // Line valid bits, cleared on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      line_valid_q <= '0;
    end else if (fill_en) begin
      line_valid_q[fill_idx] <= 1'b1;
    end
  end

  // Line tag and data storage, overwritten on every fill
  always_ff @(posedge clock) begin
    if (fill_en) begin
      line_tag_q[fill_idx]  <= req_addr_q[XLEN-1 -: TAG_W];
      line_data_q[fill_idx] <= Imem2proc_data;
    end
  end

  assign proc2Imem_command = cmd_q;
  assign proc2Imem_addr    = mem_addr_q;

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch (default build, N_WAY = 3).
module tb_icache_fetch;

  localparam int unsigned NW = 3;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [31:0]         fetch_addr;
  logic [2:0]          fetch_cnt;
  logic [NW-1:0][31:0] o_addr;
  logic [NW-1:0][31:0] o_data;
  logic [NW-1:0]       o_valid;
  logic [2:0]          o_hc;
  logic [1:0]          mem_cmd;
  logic [31:0]         mem_addr;
  logic [3:0]          mem_resp;
  logic [63:0]         mem_data;
  logic [3:0]          mem_tag;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  prev_cmd = 2'd0;

  localparam logic [31:0] D0 = 32'h00100093;
  localparam logic [31:0] D1 = 32'h00000013;
  localparam logic [31:0] E0 = 32'h11111111;
  localparam logic [31:0] E1 = 32'h22222222;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  cnt;
    logic [2:0]  valid;
    logic [2:0]  hc;
    logic [31:0] d0, d1, d2;
    logic        req;
    logic [31:0] req_addr;
  } vec_t;
  vec_t vecs[10];

  always #5 clock = ~clock;

  icache_fetch #(.N_WAY(NW), .XLEN(32), .CACHE_LINES(32), .MEM_TAG_W(4)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .buff2Icache_addr      (fetch_addr),
    .buff2Icache_count     (fetch_cnt),
    .Icache2buff_addr      (o_addr),
    .Icache2buff_data      (o_data),
    .Icache2buff_valid     (o_valid),
    .Icache2buff_hit_count (o_hc),
    .proc2Imem_command     (mem_cmd),
    .proc2Imem_addr        (mem_addr),
    .Imem2proc_response    (mem_resp),
    .Imem2proc_data        (mem_data),
    .Imem2proc_tag         (mem_tag)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fetch(input logic [31:0] a, input logic [2:0] c);
    fetch_addr = a;
    fetch_cnt  = c;
  endtask

  task automatic check_lookup(input string nm, input logic [31:0] base, input logic [2:0] ev,
                              input logic [2:0] ehc, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2);
    logic [31:0] ed[3];
    #1;
    ed[0] = e0; ed[1] = e1; ed[2] = e2;
    chk({nm, "_valid"}, 64'(o_valid), 64'(ev));
    chk({nm, "_hitcnt"}, 64'(o_hc), 64'(ehc));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_addr%0d", nm, i), 64'(o_addr[i]), 64'(ev[i] ? base + 32'(4 * i) : 32'h0));
      chk($sformatf("%s_data%0d", nm, i), 64'(o_data[i]), 64'(ev[i] ? ed[i] : 32'h0));
    end
  endtask

  task automatic check_mem(input string nm, input logic [1:0] ecmd, input logic [31:0] eaddr);
    chk({nm, "_cmd"}, 64'(mem_cmd), 64'(ecmd));
    chk({nm, "_addr"}, 64'(mem_addr), 64'(eaddr));
  endtask

  // Scoreboard: every newly issued LOAD must match the next expected line address
  always @(negedge clock) begin
    if (!reset && mem_cmd == 2'd1 && prev_cmd != 2'd1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_load", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("sb_load_addr", 64'(mem_addr), 64'(exp_q.pop_front()));
      end
    end
    prev_cmd = mem_cmd;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0,   3'd0, 3'b000, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0};
    vecs[1] = '{32'h0,   3'd1, 3'b001, 3'd1, D0,    32'h0, 32'h0, 1'b0, 32'h0};
    vecs[2] = '{32'h0,   3'd2, 3'b011, 3'd2, D0,    D1,    32'h0, 1'b0, 32'h0};
    vecs[3] = '{32'h4,   3'd2, 3'b011, 3'd2, D1,    E0,    32'h0, 1'b0, 32'h0};
    vecs[4] = '{32'h8,   3'd3, 3'b011, 3'd2, E0,    E1,    32'h0, 1'b1, 32'h10};
    vecs[5] = '{32'hC,   3'd7, 3'b001, 3'd1, E1,    32'h0, 32'h0, 1'b0, 32'h0};
    vecs[6] = '{32'h10,  3'd3, 3'b000, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0};
    vecs[7] = '{32'h6,   3'd3, 3'b111, 3'd3, D1,    E0,    E1,    1'b0, 32'h0};
    vecs[8] = '{32'h100, 3'd1, 3'b000, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0};
    vecs[9] = '{32'h4,   3'd4, 3'b111, 3'd3, D1,    E0,    E1,    1'b0, 32'h0};

    set_fetch(32'h0, 3'd0);
    mem_resp = '0; mem_tag = '0; mem_data = '0;
    reset = 1'b1;
    tick(); tick();
    check_mem("reset", 2'd0, 32'h0);
    check_lookup("reset", 32'h0, 3'b000, 3'd0, 0, 0, 0);
    reset = 1'b0;

    // Cold miss on line 0x0, accepted with tag 2
    tick();
    set_fetch(32'h0, 3'd3);
    exp_q.push_back(32'h0);
    check_lookup("cold", 32'h0, 3'b000, 3'd0, 0, 0, 0);
    tick();
    check_mem("req0", 2'd1, 32'h0);
    mem_resp = 4'd2;
    tick();
    mem_resp = '0;
    check_mem("wait0", 2'd0, 32'h0);
    tick();
    mem_tag = 4'd2; mem_data = {D1, D0};
    check_lookup("nobypass", 32'h0, 3'b000, 3'd0, 0, 0, 0);
    tick();
    mem_tag = '0; mem_data = '0;
    exp_q.push_back(32'h8);
    check_lookup("fill0", 32'h0, 3'b011, 3'd2, D0, D1, 0);

    // Line 0x8 request rejected three times, then accepted with tag 5
    for (int r = 0; r < 4; r++) begin
      tick();
      check_mem($sformatf("retry%0d", r), 2'd1, 32'h8);
      if (r == 3) mem_resp = 4'd5;
    end
    tick();
    mem_resp = '0;
    check_mem("wait8", 2'd0, 32'h0);
    set_fetch(32'h8, 3'd1);
    mem_tag = 4'd4; mem_data = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    mem_tag = '0; mem_data = '0;
    check_mem("wrongtag", 2'd0, 32'h0);
    check_lookup("wrongtag", 32'h8, 3'b000, 3'd0, 0, 0, 0);
    tick();
    mem_tag = 4'd5; mem_data = {E1, E0};
    tick();
    mem_tag = '0; mem_data = '0;
    set_fetch(32'h4, 3'd3);
    check_lookup("span", 32'h4, 3'b111, 3'd3, D1, E0, E1);
    tick();

    // Table of lookups with lines 0x0 and 0x8 resident
    for (int v = 0; v < 10; v++) begin
      set_fetch(vecs[v].addr, vecs[v].cnt);
      if (vecs[v].req) exp_q.push_back(vecs[v].req_addr);
      check_lookup($sformatf("vec%0d", v), vecs[v].addr, vecs[v].valid, vecs[v].hc,
                   vecs[v].d0, vecs[v].d1, vecs[v].d2);
      tick();
    end

    // Line 0x10 fill, hits served while the miss is outstanding
    check_mem("req10", 2'd1, 32'h10);
    mem_resp = 4'd1;
    set_fetch(32'h0, 3'd1);
    tick();
    mem_resp = '0;
    check_mem("wait10", 2'd0, 32'h0);
    check_lookup("hit_under_miss", 32'h0, 3'b001, 3'd1, D0, 0, 0);
    tick();
    mem_tag = 4'd1; mem_data = 64'h44444444_33333333;
    tick();
    mem_tag = '0; mem_data = '0;
    set_fetch(32'hC, 3'd3);
    check_lookup("fill10", 32'hC, 3'b111, 3'd3, E1, 32'h33333333, 32'h44444444);

    // Line 0x100 evicts line 0x0
    tick();
    set_fetch(32'h100, 3'd1);
    exp_q.push_back(32'h100);
    check_lookup("miss100", 32'h100, 3'b000, 3'd0, 0, 0, 0);
    tick();
    check_mem("req100", 2'd1, 32'h100);
    mem_resp = 4'd6;
    set_fetch(32'h0, 3'd1);
    tick();
    mem_resp = '0;
    tick();
    mem_tag = 4'd6; mem_data = 64'h66666666_55555555;
    tick();
    mem_tag = '0; mem_data = '0;
    set_fetch(32'h0, 3'd0);
    check_mem("idle100", 2'd0, 32'h0);
    tick();
    check_mem("no_prefetch_a", 2'd0, 32'h0);
    tick();
    check_mem("no_prefetch_b", 2'd0, 32'h0);
    set_fetch(32'h100, 3'd2);
    check_lookup("fill100", 32'h100, 3'b011, 3'd2, 32'h55555555, 32'h66666666, 0);
    tick();
    set_fetch(32'h4, 3'd3);
    exp_q.push_back(32'h0);
    check_lookup("evicted", 32'h4, 3'b000, 3'd0, 0, 0, 0);

    // Reset while waiting on tag 3; the late tag 3 must not write a line
    tick();
    check_mem("req0b", 2'd1, 32'h0);
    mem_resp = 4'd3;
    set_fetch(32'h0, 3'd0);
    tick();
    mem_resp = '0;
    check_mem("wait0b", 2'd0, 32'h0);
    reset = 1'b1;
    #1;
    check_mem("midreset", 2'd0, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    mem_tag = 4'd3; mem_data = 64'h77777777_77777777;
    tick();
    mem_tag = '0; mem_data = '0;
    set_fetch(32'h0, 3'd1);
    exp_q.push_back(32'h0);
    check_lookup("stale_tag", 32'h0, 3'b000, 3'd0, 0, 0, 0);
    tick();
    check_mem("req_after_reset", 2'd1, 32'h0);
    set_fetch(32'h0, 3'd0);
    tick();
    chk("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
